treeval_param: RTL and testbench

Parametrised successor to the fixed-size tree evaluator in the reinforce-accelerator datapath. It holds a configurable decision tree of up to `N_NODES` nodes, including per-node parent, reward, action and weight. On a `start` pulse it computes the root's expected value bottom-up in signed fixed point, one node per cycle. It also selects the action of the best root child. Unlike its predecessor it has explicit start/busy/done handshaking, generic widths and depth, intermediate-node rewards, and invalid-edge detection.

---
 rtl/treeval_param.sv | 202 ++++++++++++++++++++
 tb/tb_treeval_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/treeval_param.sv
// treeval_param: parametrised decision-tree evaluator.
// Holds up to N_NODES nodes (parent, reward, action, weight). On start it folds
// child values into their parents bottom-up, one node per cycle, and reports the
// root expected value and the action of the best root child.
// Build option: define TREEVAL_SAT_EN to saturate each accumulation instead of
// letting it wrap to W_REWARD bits.
module treeval_param #(
   parameter int N_NODES  = 1024,
   parameter int W_ADDR   = $clog2(N_NODES),
   parameter int W_DATA   = 12,
   parameter int W_REWARD = 12,
   parameter int W_ACTION = 3,
   parameter int W_FRAC   = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_par,
   input  logic                       mem_rew,
   input  logic                       mem_act,
   input  logic                       mem_weight,
   input  logic [W_ADDR-1:0]          mem_addr,
   input  logic [W_DATA-1:0]          mem_data,
   input  logic                       conf_nodes,
   input  logic [W_ADDR:0]            conf_data,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic signed [W_REWARD-1:0] exp,
   output logic [W_ACTION-1:0]        act,
   output logic                       exp_change,
   output logic                       err
);

   localparam int W_PROD = W_REWARD + W_DATA + 1;   // signed value x unsigned weight
   localparam int W_SUM  = W_PROD + 1;              // parent value + contribution

   localparam logic [W_ADDR:0]   N_LIM    = (W_ADDR+1)'(N_NODES);
   localparam logic [W_ADDR:0]   ONE_N    = (W_ADDR+1)'(1);
   localparam logic [W_ADDR-1:0] ONE_IDX  = W_ADDR'(1);
   localparam logic signed [W_REWARD-1:0] MOST_NEG = {1'b1, {(W_REWARD-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INIT = 2'd1;
   localparam logic [1:0] S_SCAN = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Reduce a widened accumulation back to the value width.
   function automatic logic signed [W_REWARD-1:0] reduce_val(input logic signed [W_SUM-1:0] s);
`ifdef TREEVAL_SAT_EN
      logic signed [W_SUM-1:0] hi;
      logic signed [W_SUM-1:0] lo;
      hi = W_SUM'((1 << (W_REWARD-1)) - 1);
      lo = ~hi;
      if (s > hi)
         return W_REWARD'(hi);
      else if (s < lo)
         return W_REWARD'(lo);
      else
         return W_REWARD'(s);
`else
      return W_REWARD'(s);
`endif
   endfunction

   logic [1:0]                 state;
   logic [W_ADDR:0]            n_nodes;
   logic [W_ADDR-1:0]          idx;
   logic signed [W_REWARD-1:0] best_val;
   logic [W_ACTION-1:0]        best_act;

   logic [W_ADDR-1:0]          par_mem [N_NODES];
   logic signed [W_REWARD-1:0] rew_mem [N_NODES];
   logic [W_ACTION-1:0]        act_mem [N_NODES];
   logic [W_DATA-1:0]          wgt_mem [N_NODES];
   logic signed [W_REWARD-1:0] val_mem [N_NODES];

   logic                       wr_ok;
   logic [W_ADDR:0]            conf_clamped;
   logic [W_ADDR-1:0]          cur_par;
   logic signed [W_REWARD-1:0] cur_val;
   logic signed [W_REWARD-1:0] par_val;
   logic [W_DATA-1:0]          cur_w;
   logic                       edge_ok;
   logic signed [W_PROD-1:0]   val_ext;
   logic signed [W_PROD-1:0]   wgt_ext;
   logic signed [W_PROD-1:0]   prod;
   logic signed [W_PROD-1:0]   contrib;
   logic signed [W_SUM-1:0]    sum;
   logic signed [W_REWARD-1:0] new_val;

   assign busy  = (state != S_IDLE);
   assign wr_ok = (state == S_IDLE) && ({1'b0, mem_addr} < N_LIM);

   // Clamp the requested node count to [1, N_NODES].
   always_comb begin
      conf_clamped = conf_data;
      if (conf_data == '0)
         conf_clamped = ONE_N;
      else if (conf_data > N_LIM)
         conf_clamped = N_LIM;
   end

   // Scan datapath: weighted contribution of node idx folded into its parent.
   always_comb begin
      cur_par = par_mem[idx];
      cur_val = val_mem[idx];
      cur_w   = wgt_mem[idx];
      par_val = val_mem[cur_par];
      edge_ok = (cur_par < idx);
      val_ext = {{(W_PROD-W_REWARD){cur_val[W_REWARD-1]}}, cur_val};
      wgt_ext = {{(W_PROD-W_DATA){1'b0}}, cur_w};
      prod    = val_ext * wgt_ext;
      contrib = prod >>> W_FRAC;
      sum     = {contrib[W_PROD-1], contrib} + {{(W_SUM-W_REWARD){par_val[W_REWARD-1]}}, par_val};
      new_val = reduce_val(sum);
   end

   // Control FSM, best-child tracking and registered results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         n_nodes    <= ONE_N;
         idx        <= '0;
         best_val   <= '0;
         best_act   <= '0;
         err        <= 1'b0;
         done       <= 1'b0;
         exp        <= '0;
         act        <= '0;
         exp_change <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (conf_nodes)
                  n_nodes <= conf_clamped;
               // A start landing on the done cycle is dropped.
               if (start && !done)
                  state <= S_INIT;
            end
            S_INIT: begin
               err      <= 1'b0;
               best_val <= MOST_NEG;
               best_act <= '0;
               idx      <= W_ADDR'(n_nodes - ONE_N);
               state    <= (n_nodes == ONE_N) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
               if (!edge_ok)
                  err <= 1'b1;
               // Descending scan with >= hands ties to the lowest index.
               if (cur_par == '0 && cur_val >= best_val) begin
                  best_val <= cur_val;
                  best_act <= act_mem[idx];
               end
               if (idx == ONE_IDX)
                  state <= S_DONE;
               else
                  idx <= idx - ONE_IDX;
            end
            default: begin
               exp        <= val_mem[0];
               act        <= best_act;
               exp_change <= (val_mem[0] != exp) || (best_act != act);
               done       <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   // Host writes into the static tree description, accepted only while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_NODES; k++) begin
            par_mem[k] <= '0;
            rew_mem[k] <= '0;
            act_mem[k] <= '0;
            wgt_mem[k] <= '0;
         end
      end else if (wr_ok) begin
         if (mem_par)    par_mem[mem_addr] <= mem_data[W_ADDR-1:0];
         if (mem_rew)    rew_mem[mem_addr] <= mem_data[W_REWARD-1:0];
         if (mem_act)    act_mem[mem_addr] <= mem_data[W_ACTION-1:0];
         if (mem_weight) wgt_mem[mem_addr] <= mem_data;
      end
   end

   // Working values: seeded from rewards, then accumulated during the scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_NODES; k++)
            val_mem[k] <= '0;
      end else if (state == S_INIT) begin
         for (int k = 0; k < N_NODES; k++)
            val_mem[k] <= rew_mem[k];
      end else if (state == S_SCAN && edge_ok) begin
         val_mem[cur_par] <= new_val;
      end
   end

endmodule

// File: tb/tb_treeval_param.sv
// tb_treeval_param: directed and randomized checks of treeval_param against a
// node-by-node reference evaluation of the tree.
module tb_treeval_param;

   localparam int NN   = 1024;
   localparam int WA   = 10;
   localparam int WD   = 12;
   localparam int WR   = 12;
   localparam int WACT = 3;
   localparam int WF   = 7;
   localparam int VMAX = (1 << (WR-1)) - 1;
   localparam int VMIN = -(1 << (WR-1));

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            mem_par = 1'b0, mem_rew = 1'b0, mem_act = 1'b0, mem_weight = 1'b0;
   logic [WA-1:0]   mem_addr = '0;
   logic [WD-1:0]   mem_data = '0;
   logic            conf_nodes = 1'b0;
   logic [WA:0]     conf_data = '0;
   logic            start = 1'b0;
   logic            busy, done, exp_change, err;
   logic [WR-1:0]   exp;
   logic [WACT-1:0] act;

   int nvec = 0;
   int nmis = 0;
   int m_par [64];
   int m_rew [64];
   int m_act [64];
   int m_w   [64];
   int prev_e = 0;
   int prev_a = 0;

   treeval_param #(.N_NODES(NN), .W_DATA(WD), .W_REWARD(WR), .W_ACTION(WACT), .W_FRAC(WF)) dut (
      .clk(clk), .rst(rst),
      .mem_par(mem_par), .mem_rew(mem_rew), .mem_act(mem_act), .mem_weight(mem_weight),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .conf_nodes(conf_nodes), .conf_data(conf_data),
      .start(start), .busy(busy), .done(done),
      .exp(exp), .act(act), .exp_change(exp_change), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
      nvec++;
      assert (obs === req) else begin
         nmis++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, req);
      end
   endtask

   // Value reduction as the tree arithmetic defines it.
   function automatic int red(input longint s);
`ifdef TREEVAL_SAT_EN
      if (s > VMAX) return VMAX;
      if (s < VMIN) return VMIN;
      return int'(s);
`else
      longint m;
      m = s & longint'((1 << WR) - 1);
      if (m > VMAX) m = m - longint'(1 << WR);
      return int'(m);
`endif
   endfunction

   // Each node's value = its reward plus the weighted values of its children
   // (children visited from highest index down); best root child by strict max
   // over ascending indices.
   task automatic model(input int n, output int e, output int a, output int er);
      int v [64];
      longint acc;
      int best;
      er = 0;
      for (int j = 1; j < n; j++) if (m_par[j] >= j) er = 1;
      for (int k = n - 1; k >= 0; k--) begin
         acc = m_rew[k];
         for (int j = n - 1; j > k; j--)
            if (m_par[j] == k) acc = red(acc + ((longint'(v[j]) * m_w[j]) >>> WF));
         v[k] = int'(acc);
      end
      a = 0;
      best = VMIN - 1;
      for (int j = 1; j < n; j++)
         if (m_par[j] == 0 && v[j] > best) begin
            best = v[j];
            a = m_act[j];
         end
      e = v[0];
   endtask

   task automatic wr(input int sel, input int addr, input int data);
      logic [31:0] a32, d32;
      a32 = addr;
      d32 = data;
      @(negedge clk);
      mem_addr   = a32[WA-1:0];
      mem_data   = d32[WD-1:0];
      mem_par    = (sel == 0);
      mem_rew    = (sel == 1);
      mem_act    = (sel == 2);
      mem_weight = (sel == 3);
      @(negedge clk);
      mem_par = 1'b0; mem_rew = 1'b0; mem_act = 1'b0; mem_weight = 1'b0;
   endtask

   task automatic node(input int i, input int p, input int r, input int a, input int w);
      m_par[i] = p; m_rew[i] = r; m_act[i] = a; m_w[i] = w;
      wr(0, i, p); wr(1, i, r); wr(2, i, a); wr(3, i, w);
   endtask

   task automatic set_n(input int n);
      logic [31:0] n32;
      n32 = n;
      @(negedge clk);
      conf_data  = n32[WA:0];
      conf_nodes = 1'b1;
      @(negedge clk);
      conf_nodes = 1'b0;
   endtask

   // Pulse start and wait (bounded) for done; lat counts edges after the start edge.
   task automatic run(input bit interfere, input bit poke, output int lat, output logic busy_after);
      lat = -1;
      busy_after = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (interfere && c == 1) begin
            chk("busy_after_start", 32'(busy), 1);
            mem_rew = 1'b1; mem_addr = '0; mem_data = 12'd500;
            conf_data = 11'd2; conf_nodes = 1'b1;
            start = 1'b1;
         end else if (interfere && c == 2) begin
            mem_rew = 1'b0; conf_nodes = 1'b0;
            chk("busy_done_overlap", 32'(busy & done), 0);
         end
         if (done === 1'b1) begin
            lat = c - 1;
            break;
         end
      end
      if (poke) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         busy_after = busy;
      end
   endtask

   task automatic expect_run(input string tag, input int lat, input int lat_req,
                             input int e, input int a, input int er);
      chk({tag, ".latency"}, lat, lat_req);
      chk({tag, ".exp"}, 32'($signed(exp)), e);
      chk({tag, ".act"}, 32'(act), a);
      chk({tag, ".err"}, 32'(err), er);
      chk({tag, ".exp_change"}, 32'(exp_change), 32'((e != prev_e) || (a != prev_a)));
      prev_e = e;
      prev_a = a;
   endtask

   initial begin
      int lat, e, a, er, n, amp, dcnt;
      logic ba;

      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.exp", 32'($signed(exp)), 0);
      chk("rst.act", 32'(act), 0);
      chk("rst.exp_change", 32'(exp_change), 0);
      chk("rst.err", 32'(err), 0);

      // reference 7-node tree, with writes/start/conf attempted while busy
      node(0, 0, 0, 0, 0);
      node(1, 0, 0, 1, 64);
      node(2, 0, -10, 1, 64);
      node(3, 0, 0, 0, 100);
      node(4, 1, 100, 1, 64);
      node(5, 1, -50, 1, 64);
      node(6, 1, 10, 0, 128);
      set_n(7);
      run(1'b1, 1'b0, lat, ba);
      expect_run("ref", lat, 8, 12, 1, 0);

      // same tree again; a start on the done cycle must not be taken
      run(1'b0, 1'b1, lat, ba);
      expect_run("rerun", lat, 8, 12, 1, 0);
      chk("start_on_done_ignored", 32'(ba), 0);

      // accumulation overflow
      node(0, 0, 0, 0, 0);
      node(1, 0, 1000, 2, 256);
      node(2, 0, 1000, 5, 256);
      set_n(3);
      run(1'b0, 1'b0, lat, ba);
`ifdef TREEVAL_SAT_EN
      expect_run("sat", lat, 4, 2047, 2, 0);
`else
      expect_run("wrap", lat, 4, -96, 2, 0);
`endif

      // invalid edge: node 2 points forward and must be skipped
      node(0, 0, 0, 0, 0);
      node(1, 0, 20, 3, 128);
      node(2, 5, 30, 6, 128);
      set_n(3);
      run(1'b0, 1'b0, lat, ba);
      expect_run("bad_edge", lat, 4, 20, 3, 1);

      // single node (count 0 clamps to 1)
      node(0, 0, -7, 4, 0);
      set_n(0);
      run(1'b0, 1'b0, lat, ba);
      expect_run("single", lat, 2, -7, 0, 0);

      // reset three cycles into the scan of the 7-node tree
      node(0, 0, 55, 0, 0);
      node(1, 0, 0, 1, 64);
      node(2, 0, -10, 1, 64);
      node(3, 0, 0, 0, 100);
      node(4, 1, 100, 1, 64);
      node(5, 1, -50, 1, 64);
      node(6, 1, 10, 0, 128);
      set_n(7);
      @(negedge clk);
      start = 1'b1;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("abort.busy_in_rst", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done !== 1'b0) dcnt++;
      end
      chk("abort.no_done", dcnt, 0);
      chk("abort.exp", 32'($signed(exp)), 0);
      chk("abort.act", 32'(act), 0);
      chk("abort.err", 32'(err), 0);
      chk("abort.exp_change", 32'(exp_change), 0);
      chk("abort.busy", 32'(busy), 0);
      for (int k = 0; k < 64; k++) begin
         m_par[k] = 0; m_rew[k] = 0; m_act[k] = 0; m_w[k] = 0;
      end
      prev_e = 0;
      prev_a = 0;
      model(1, e, a, er);
      run(1'b0, 1'b0, lat, ba);
      expect_run("after_abort", lat, 2, e, a, er);

      // randomized trees
      for (int t = 0; t < 20; t++) begin
         n = $urandom_range(2, 24);
         amp = (t % 2 == 1) ? 2047 : 300;
         for (int i = 0; i < n; i++) begin
            int p;
            if (i == 0) p = 0;
            else if ($urandom_range(0, 9) == 0) p = $urandom_range(i, i + 5);
            else p = $urandom_range(0, i - 1);
            node(i, p, $urandom_range(0, 2 * amp) - amp, $urandom_range(0, 7), $urandom_range(0, 300));
         end
         set_n(n);
         model(n, e, a, er);
         run(1'b0, 1'b0, lat, ba);
         expect_run($sformatf("rand%0d", t), lat, n + 1, e, a, er);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
